// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor_cell.sv
// One-bit full subtractor (x - y - bin) built from two half-subtractor stages.
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic b
);

   assign d = x ^ y;
   assign b = ~x & y;

endmodule

module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1;
   logic b1;
   logic b2;

   half_subtractor u_hs_xy (
      .x (x),
      .y (y),
      .d (d1),
      .b (b1)
   );

   half_subtractor u_hs_bin (
      .x (d1),
      .y (bin),
      .d (d),
      .b (b2)
   );

   assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clk; result and final borrow published on done.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; diff/borrow_out hold the last result
// ST_SHIFT | one operand bit consumed per clock, borrow carried in br_q
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d;
   logic [WIDTH-1:0]   sb_q, sb_d;
   logic [WIDTH-2:0]   res_q, res_d;
   logic               br_q, br_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_q, borrow_d;

   logic               cell_d;
   logic               cell_bout;
   logic [WIDTH-1:0]   res_next;

   full_subtractor_cell u_cell (
      .x    (sa_q[0]),
      .y    (sb_q[0]),
      .bin  (br_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // The top WIDTH-1 bits of the shifted result live in res_q; the final bit
   // arrives straight from the cell on the completion edge.
   assign res_next = {cell_d, res_q};

   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      res_d    = res_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      diff_d   = diff_q;
      borrow_d = borrow_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            res_d = res_next[WIDTH-1:1];
            sa_d  = {1'b0, sa_q[WIDTH-1:1]};
            sb_d  = {1'b0, sb_q[WIDTH-1:1]};
            br_d  = cell_bout;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               diff_d   = res_next;
               borrow_d = cell_bout;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         res_q    <= res_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   assign busy       = (state_q == ST_SHIFT);
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_q;

endmodule
